// File: rtl/etapa_fetch_if.sv
// Fetch-stage bus: instruction-memory port, branch redirect from execute,
// and the valid/ready handshake towards decode, plus buffer occupancy.
//
// Handshake: an entry moves from fetch to decode in a cycle exactly when
// dec_valid and dec_ready are both high at the rising edge of clk and no
// redirect is requested. dec_valid/dec_instr/dec_pc4 are driven from
// registers only and stay stable until that transfer happens. dec_ready
// may depend on anything and is ignored while dec_valid is low.
interface etapa_fetch_if;
    logic [31:0] imem_adr;
    logic [31:0] imem_instr;
    logic        br_taken;
    logic [31:0] br_target;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc4;
    logic [1:0]  occ;

    // Fetch stage side
    modport master (
        output imem_adr,
        output dec_valid,
        output dec_instr,
        output dec_pc4,
        output occ,
        input  imem_instr,
        input  br_taken,
        input  br_target,
        input  dec_ready
    );

    // Environment side: memory, execute and decode
    modport slave (
        input  imem_adr,
        input  dec_valid,
        input  dec_instr,
        input  dec_pc4,
        input  occ,
        output imem_instr,
        output br_taken,
        output br_target,
        output dec_ready
    );
endinterface

// File: rtl/etapa_fetch.sv
// Instruction fetch stage: a PC register drives the instruction memory and
// every fetched word is stored with its PC+4 in a two-entry buffer that
// feeds decode. A taken branch flushes the buffer and redirects the PC.
// The buffer decouples decode from the memory, so dec_* never depends
// combinationally on imem_instr.
module etapa_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int unsigned DEPTH    = 2
) (
    input logic          clk,
    input logic          rst,
    etapa_fetch_if.master fetch
);

    // DEPTH is fixed at 2, so a single pointer bit addresses the buffer
    // and a two-bit count covers 0..2.
    localparam logic [1:0] FULL_OCC = 2'(DEPTH);

    // Architectural state
    logic [31:0] pc_q, pc_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  occ_q, occ_d;
    logic [31:0] buf_instr_q [DEPTH];
    logic [31:0] buf_pc4_q   [DEPTH];

    // Per-cycle events
    logic        push;
    logic        pop;
    logic        not_empty;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_pc;

    // The two lowest target bits are dropped: fetch is word aligned.
    logic unused_tgt_lsbs;
    assign unused_tgt_lsbs = ^fetch.br_target[1:0];

    assign not_empty   = (occ_q != 2'd0);
    assign pc_plus4    = pc_q + 32'd4;
    assign redirect_pc = {fetch.br_target[31:2], 2'b00};

    // Transfer decisions: a redirect suppresses both push and pop; a full
    // buffer can still accept a word when the head leaves the same cycle.
    always_comb begin
        pop  = 1'b0;
        push = 1'b0;
        if (!fetch.br_taken) begin
            pop  = not_empty && fetch.dec_ready;
            push = (occ_q != FULL_OCC) || pop;
        end
    end

    // Next-state for PC, pointers and occupancy; redirect wins over all.
    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (fetch.br_taken) begin
            pc_d     = redirect_pc;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            occ_d    = 2'd0;
        end else begin
            if (push) begin
                pc_d     = pc_plus4;
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            occ_d = occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Control register update; reset overrides redirect and handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Buffer storage: write {PC+4, instruction} at the tail on push.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                buf_instr_q[i] <= 32'h0;
                buf_pc4_q[i]   <= 32'h0;
            end
        end else if (push) begin
            buf_instr_q[wr_ptr_q] <= fetch.imem_instr;
            buf_pc4_q[wr_ptr_q]   <= pc_plus4;
        end
    end

    // Outputs: head entry when non-empty, zeros otherwise.
    always_comb begin
        fetch.imem_adr  = pc_q;
        fetch.occ       = occ_q;
        fetch.dec_valid = not_empty;
        fetch.dec_instr = 32'h0;
        fetch.dec_pc4   = 32'h0;
        if (not_empty) begin
            fetch.dec_instr = buf_instr_q[rd_ptr_q];
            fetch.dec_pc4   = buf_pc4_q[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_etapa_fetch.sv
// Directed bench for the fetch stage. Instruction memory is modelled as
// instr = address + 1000. Instance a uses RESET_PC = 0, instance b uses
// RESET_PC = 32'hFFFFFFFC to cover PC wrap-around.
module tb_etapa_fetch;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  etapa_fetch_if bus_a ();
  etapa_fetch_if bus_b ();

  etapa_fetch #(.RESET_PC(32'h00000000), .DEPTH(2)) dut_a (
    .clk   (clk),
    .rst   (rst),
    .fetch (bus_a)
  );

  etapa_fetch #(.RESET_PC(32'hFFFFFFFC), .DEPTH(2)) dut_b (
    .clk   (clk),
    .rst   (rst),
    .fetch (bus_b)
  );

  assign bus_a.imem_instr = bus_a.imem_adr + 32'd1000;
  assign bus_b.imem_instr = bus_b.imem_adr + 32'd1000;

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one cycle; outputs are sampled 1 time unit after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [1:0] occ, input logic valid,
                         input logic [31:0] adr, input logic [31:0] instr,
                         input logic [31:0] pc4);
    check({tag, ".occ"},   {30'h0, bus_a.occ}, {30'h0, occ});
    check({tag, ".valid"}, {31'h0, bus_a.dec_valid}, {31'h0, valid});
    check({tag, ".adr"},   bus_a.imem_adr, adr);
    check({tag, ".instr"}, bus_a.dec_instr, instr);
    check({tag, ".pc4"},   bus_a.dec_pc4, pc4);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus_a.br_taken = 1'b0; bus_a.br_target = 32'h0; bus_a.dec_ready = 1'b0;
    bus_b.br_taken = 1'b0; bus_b.br_target = 32'h0; bus_b.dec_ready = 1'b1;

    // reset state
    cyc();
    cyc();
    check_a("reset", 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    check("reset_b.adr", bus_b.imem_adr, 32'hFFFFFFFC);

    // streaming with dec_ready=1: one instruction per cycle
    rst = 1'b0;
    bus_a.dec_ready = 1'b1;
    #1;
    check("rel_a.adr", bus_a.imem_adr, 32'h0);
    check("rel_b.adr", bus_b.imem_adr, 32'hFFFFFFFC);
    cyc();
    check_a("stream1", 2'd1, 1'b1, 32'd4, 32'd1000, 32'd4);
    check("wrap_b.pc4",   bus_b.dec_pc4, 32'h0);
    check("wrap_b.instr", bus_b.dec_instr, 32'hFFFFFFFC + 32'd1000);
    check("wrap_b.adr",   bus_b.imem_adr, 32'h0);
    cyc();
    check_a("stream2", 2'd1, 1'b1, 32'd8, 32'd1004, 32'd8);
    check("wrap2_b.pc4",   bus_b.dec_pc4, 32'd4);
    check("wrap2_b.instr", bus_b.dec_instr, 32'd1000);
    cyc();
    check_a("stream3", 2'd1, 1'b1, 32'd12, 32'd1008, 32'd12);

    // mid-stream reset discards entries, then stall with dec_ready=0
    rst = 1'b1;
    bus_a.dec_ready = 1'b0;
    cyc();
    check_a("rst2", 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    rst = 1'b0;
    cyc();
    check_a("fill1", 2'd1, 1'b1, 32'd4, 32'd1000, 32'd4);
    cyc();
    check_a("fill2", 2'd2, 1'b1, 32'd8, 32'd1000, 32'd4);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_a("stall", 2'd2, 1'b1, 32'd8, 32'd1000, 32'd4);
    end

    // release: pc4 continues 8, 12, 16 with no gap, occ stays at 2
    bus_a.dec_ready = 1'b1;
    cyc();
    check_a("drain1", 2'd2, 1'b1, 32'd12, 32'd1004, 32'd8);
    cyc();
    check_a("drain2", 2'd2, 1'b1, 32'd16, 32'd1008, 32'd12);
    cyc();
    check_a("drain3", 2'd2, 1'b1, 32'd20, 32'd1012, 32'd16);

    // redirect at full buffer while decode is ready
    bus_a.br_taken = 1'b1;
    bus_a.br_target = 32'h40;
    cyc();
    bus_a.br_taken = 1'b0;
    bus_a.dec_ready = 1'b0;
    check_a("flush", 2'd0, 1'b0, 32'h40, 32'h0, 32'h0);
    cyc();
    check_a("after_flush", 2'd1, 1'b1, 32'h44, 32'h40 + 32'd1000, 32'h44);

    // unaligned redirect target is forced to a word address
    bus_a.br_taken = 1'b1;
    bus_a.br_target = 32'h43;
    cyc();
    bus_a.br_taken = 1'b0;
    check_a("align", 2'd0, 1'b0, 32'h40, 32'h0, 32'h0);
    cyc();
    check_a("align_fill1", 2'd1, 1'b1, 32'h44, 32'h40 + 32'd1000, 32'h44);
    cyc();
    check_a("align_fill2", 2'd2, 1'b1, 32'h48, 32'h40 + 32'd1000, 32'h44);

    // reset together with a redirect: reset wins
    rst = 1'b1;
    bus_a.br_taken = 1'b1;
    bus_a.br_target = 32'h80;
    cyc();
    check_a("rst_br", 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    rst = 1'b0;
    bus_a.br_taken = 1'b0;
    cyc();
    check_a("rst_br_fetch", 2'd1, 1'b1, 32'd4, 32'd1000, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global time bound
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
